// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read engine: RAM read port to valid/ready stream
// Credit-based issue keeps (buffered + in-flight) words <= 2 so the 2-entry FIFO never overflows.
module ram_burst_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, r_addr_q;
  logic [ADDR_W:0]   issue_cnt, beat_cnt;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              accept, issue, pop, done_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A zero-length command still passes through DRAIN so busy covers one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DRAIN : RUN;
      RUN:     if (issue && issue_cnt == CNT_ONE) state_nxt = DRAIN;
      DRAIN:   if (done_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && start;
    pop      = (count != 2'd0) && m_ready;
    issue    = (state == RUN) && (issue_cnt != '0) &&
               ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);
    done_nxt = (state == DRAIN) && ((beat_cnt == '0) || (beat_cnt == CNT_ONE && pop));
    busy     = (state != IDLE);
    m_valid  = (count != 2'd0);
    m_data   = fifo_mem[rd_ptr];
    r_addr   = issue ? addr_cnt : r_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done        <= 1'b0;
      inflight    <= 1'b0;
      addr_cnt    <= '0;
      r_addr_q    <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      done     <= done_nxt;
      inflight <= issue;
      if (accept) begin
        addr_cnt  <= base_addr;
        issue_cnt <= len;
        beat_cnt  <= len;
      end else begin
        if (issue) begin
          r_addr_q  <= addr_cnt;
          addr_cnt  <= addr_cnt + ADDR_ONE;
          issue_cnt <= issue_cnt - CNT_ONE;
        end
        if (pop) beat_cnt <= beat_cnt - CNT_ONE;
      end
      // RAM data for an issued read lands exactly one cycle later.
      if (inflight) begin
        fifo_mem[wr_ptr] <= ram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  credit_bound: assert property (@(posedge clk) disable iff (!rst)
    (({1'b0, count} + {2'b00, inflight}) <= 3'd2) &&
    !(inflight && !pop && count == 2'd2));

endmodule
